axis_pktlimit: RTL and testbench

Packet-length limiter and monitor placed directly downstream of the AXI-stream switch output. It forwards one AXI stream with one cycle of latency. When a packet reaches a programmable maximum beat count, the block forces TLAST on that beat and discards the rest of the oversized packet. An AXI-lite slave sets the limit and reads back packet statistics.

---
 rtl/axis_pktlimit_pkg.sv | 30 +++
 rtl/axis_pktlimit.sv | 198 +++++++++++++++++++
 tb/tb_axis_pktlimit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pktlimit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pktlimit_pkg
// Description : Register map, state encoding and byte-strobe helper shared by
//               the packet-length limiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pktlimit_pkg;

  localparam logic [1:0] ADDR_MAXLEN   = 2'd0;
  localparam logic [1:0] ADDR_PKTCOUNT = 2'd1;
  localparam logic [1:0] ADDR_LASTLEN  = 2'd2;
  localparam logic [1:0] ADDR_TRUNC    = 2'd3;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] prior,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++)
      merged[k*8 +: 8] = wstrb[k] ? wdata[k*8 +: 8] : prior[k*8 +: 8];
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pktlimit.sv
`default_nettype none
// ============================================================================
// Module      : axis_pktlimit
// Description : AXI-stream packet-length limiter/monitor with an AXI-lite
//               register slave for the limit and packet statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pktlimit
  import axis_pktlimit_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH  = 4,
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LGMAXLEN          = 16,
  parameter bit OPT_LOWPOWER      = 1'b0
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  output logic [1:0]                   S_AXI_BRESP,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         S_AXIS_TLAST,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST
);

  state_t                         r_state, w_state_next;
  logic                           r_m_valid, r_m_last;
  logic [C_AXIS_DATA_WIDTH-1:0]   r_m_data;
  logic [LGMAXLEN-1:0]            r_maxlen, r_cur_max, r_beats, r_lastlen;
  logic [31:0]                    r_pktcount, r_trunccount;
  logic                           r_bvalid, r_rvalid;
  logic [31:0]                    r_rdata;

  logic                           w_s_ready, w_accept, w_load, w_first;
  logic                           w_trunc, w_out_last;
  logic [LGMAXLEN-1:0]            w_limit, w_beats_sat;
  logic [LGMAXLEN:0]              w_beats_inc;
  logic                           w_wr, w_rd, w_awready, w_arready;
  logic [1:0]                     w_waddr, w_raddr;
  logic [31:0]                    w_maxlen32, w_lastlen32, w_maxlen_wr, w_rmux;
  logic                           w_unused;

  // Readies are held low while in reset so every output reads zero.
  assign w_s_ready  = S_AXI_ARESETN && ((r_state == ST_DROP) || !r_m_valid || M_AXIS_TREADY);
  assign w_accept   = S_AXIS_TVALID && w_s_ready;
  assign w_load     = w_accept && (r_state == ST_PASS);
  assign w_first    = (r_beats == '0);
  // The first beat of a packet sees the live MAXLEN, later beats the latched copy.
  assign w_limit    = w_first ? r_maxlen : r_cur_max;
  assign w_beats_inc = {1'b0, r_beats} + {{LGMAXLEN{1'b0}}, 1'b1};
  assign w_beats_sat = (&r_beats) ? r_beats : w_beats_inc[LGMAXLEN-1:0];
  assign w_trunc    = w_load && !S_AXIS_TLAST && (w_limit != '0)
                      && (w_beats_inc == {1'b0, w_limit});
  assign w_out_last = S_AXIS_TLAST || w_trunc;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PASS: if (w_trunc) w_state_next = ST_DROP;
      ST_DROP: if (w_accept && S_AXIS_TLAST) w_state_next = ST_PASS;
      default: w_state_next = ST_PASS;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) r_state <= ST_PASS;
    else                r_state <= w_state_next;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= S_AXIS_TDATA;
      r_m_last  <= w_out_last;
    end else if (M_AXIS_TREADY) begin
      r_m_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        r_m_data <= '0;
        r_m_last <= 1'b0;
      end
    end
  end

  assign w_awready = S_AXI_ARESETN && S_AXI_AWVALID && S_AXI_WVALID && (!r_bvalid || S_AXI_BREADY);
  assign w_wr      = w_awready;
  assign w_arready = S_AXI_ARESETN && (!r_rvalid || S_AXI_RREADY);
  assign w_rd      = S_AXI_ARVALID && w_arready;
  assign w_waddr   = S_AXI_AWADDR[3:2];
  assign w_raddr   = S_AXI_ARADDR[3:2];

  always_comb begin
    w_maxlen32 = '0;
    w_maxlen32[LGMAXLEN-1:0] = r_maxlen;
    w_lastlen32 = '0;
    w_lastlen32[LGMAXLEN-1:0] = r_lastlen;
  end

  assign w_maxlen_wr = apply_wstrb(w_maxlen32, S_AXI_WDATA, S_AXI_WSTRB);

  always_comb begin
    w_rmux = '0;
    case (w_raddr)
      ADDR_MAXLEN:   w_rmux = w_maxlen32;
      ADDR_PKTCOUNT: w_rmux = r_pktcount;
      ADDR_LASTLEN:  w_rmux = w_lastlen32;
      ADDR_TRUNC:    w_rmux = r_trunccount;
      default:       w_rmux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_maxlen     <= '0;
      r_cur_max    <= '0;
      r_beats      <= '0;
      r_lastlen    <= '0;
      r_pktcount   <= '0;
      r_trunccount <= '0;
    end else begin
      if (w_wr && (w_waddr == ADDR_MAXLEN))
        r_maxlen <= w_maxlen_wr[LGMAXLEN-1:0];
      if (w_load) begin
        if (w_first) r_cur_max <= r_maxlen;
        if (w_out_last) begin
          r_beats    <= '0;
          r_lastlen  <= w_beats_sat;
          r_pktcount <= r_pktcount + 32'd1;
        end else begin
          r_beats    <= w_beats_sat;
        end
      end
      // A clear write takes priority over a same-cycle truncation.
      if (w_wr && (w_waddr == ADDR_TRUNC))
        r_trunccount <= '0;
      else if (w_trunc && !(&r_trunccount))
        r_trunccount <= r_trunccount + 32'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr)              r_bvalid <= 1'b1;
      else if (S_AXI_BREADY) r_bvalid <= 1'b0;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rmux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
        if (OPT_LOWPOWER) r_rdata <= '0;
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXIS_TREADY = w_s_ready;
  assign M_AXIS_TVALID = r_m_valid;
  assign M_AXIS_TDATA  = r_m_data;
  assign M_AXIS_TLAST  = r_m_last;

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, w_maxlen_wr};

endmodule
`default_nettype wire

// File: tb/tb_axis_pktlimit.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pktlimit
// Description : Self-checking bench for axis_pktlimit with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pktlimit;
  import axis_pktlimit_pkg::*;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN = 1'b0;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_AWREADY;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_WVALID = 1'b0, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_BVALID, S_AXI_BREADY = 1'b1;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID = 1'b0, S_AXI_ARREADY;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_RVALID, S_AXI_RREADY = 1'b1;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXIS_TVALID = 1'b0, S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        M_AXIS_TVALID, M_AXIS_TREADY = 1'b1;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axis_pktlimit dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no-handshake required=handshake", name);
  endtask

  // Packet-level reference: beat index within the input packet decides fate.
  logic [15:0] m_maxlen = '0, m_lastlen = '0;
  logic [31:0] m_pktcount = '0, m_trunc = '0;
  int          in_idx = 0, in_limit = 0, wr_pending = 0;
  logic [32:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [32:0] exp_beat, prev_beat;
  logic [31:0] exp_rd;
  logic        prev_stall = 1'b0;
  bit          bp_on = 1'b0;
  logic [31:0] rd_val;

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_maxlen};
      2'd1:    return m_pktcount;
      2'd2:    return {16'h0, m_lastlen};
      default: return m_trunc;
    endcase
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic l);
    logic olast;
    if (in_idx == 0) in_limit = int'(m_maxlen);
    in_idx++;
    if (in_limit == 0 || in_idx <= in_limit) begin
      olast = l || (in_idx == in_limit);
      exp_q.push_back({olast, d});
      if (olast) begin
        m_pktcount++;
        m_lastlen = (in_idx > 65535) ? 16'hFFFF : 16'(in_idx);
      end
      if (in_idx == in_limit && !l && m_trunc != 32'hFFFF_FFFF) m_trunc++;
    end
    if (l) in_idx = 0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a == 2'd0) begin
      if (s[0]) m_maxlen[7:0]  = d[7:0];
      if (s[1]) m_maxlen[15:8] = d[15:8];
    end
    if (a == 2'd3) m_trunc = '0;
  endtask

  // Observes the handshakes that will complete at the coming rising edge.
  always @(negedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      chk("reset_outputs",
          {M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, S_AXIS_TREADY, S_AXI_AWREADY,
           S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY, S_AXI_RVALID,
           S_AXI_RDATA, S_AXI_RRESP}, '0);
      m_maxlen = '0; m_lastlen = '0; m_pktcount = '0; m_trunc = '0;
      in_idx = 0; in_limit = 0; wr_pending = 0;
      exp_q.delete(); rd_q.delete(); prev_stall = 1'b0;
    end else begin
      if (in_limit != 0 && in_idx >= in_limit)
        chk("drop_tready", S_AXIS_TREADY, 1'b1);
      if (prev_stall)
        chk("stall_stable", {M_AXIS_TLAST, M_AXIS_TDATA}, prev_beat);
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_beat actual=%0h required=none", {M_AXIS_TLAST, M_AXIS_TDATA});
        end else begin
          exp_beat = exp_q.pop_front();
          chk("out_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, exp_beat);
        end
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_beat  = {M_AXIS_TLAST, M_AXIS_TDATA};
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdata actual=%0h required=none", S_AXI_RDATA);
        end else begin
          exp_rd = rd_q.pop_front();
          chk("rdata", {S_AXI_RRESP, S_AXI_RDATA}, {2'b00, exp_rd});
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        chk("bresp_pending", {S_AXI_BRESP, 1'b1}, {2'b00, wr_pending > 0});
        if (wr_pending > 0) wr_pending--;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) rd_q.push_back(model_reg(S_AXI_ARADDR[3:2]));
      if (S_AXIS_TVALID && S_AXIS_TREADY) model_beat(S_AXIS_TDATA, S_AXIS_TLAST);
      if (S_AXI_AWVALID && S_AXI_WVALID && S_AXI_AWREADY) begin
        chk("wready_pair", S_AXI_WREADY, 1'b1);
        model_write(S_AXI_AWADDR[3:2], S_AXI_WDATA, S_AXI_WSTRB);
        wr_pending++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge S_AXI_ACLK); #1;
      M_AXIS_TREADY = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit hs;
    int t = 0;
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d; S_AXIS_TLAST = l;
    do begin
      @(negedge S_AXI_ACLK); hs = S_AXIS_TREADY;
      @(posedge S_AXI_ACLK); #1; t++;
    end while (!hs && t < 200);
    if (!hs) timeout("s_axis_handshake");
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit gaps);
    for (int i = 1; i <= len; i++) begin
      send_beat($urandom, i == len);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge S_AXI_ACLK); #1; end
    end
  endtask

  task automatic axil_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bit hs;
    int t = 0;
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = {a, 2'b00};
    S_AXI_WVALID = 1'b1; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    do begin
      @(negedge S_AXI_ACLK); hs = S_AXI_AWREADY;
      @(posedge S_AXI_ACLK); #1; t++;
    end while (!hs && t < 200);
    if (!hs) timeout("aw_handshake");
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    t = 0;
    do begin
      @(negedge S_AXI_ACLK); hs = S_AXI_BVALID;
      @(posedge S_AXI_ACLK); #1; t++;
    end while (!hs && t < 200);
    if (!hs) timeout("b_handshake");
  endtask

  task automatic axil_read(input logic [1:0] a, output logic [31:0] d);
    bit hs;
    int t = 0;
    d = '0;
    S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = {a, 2'b00};
    do begin
      @(negedge S_AXI_ACLK); hs = S_AXI_ARREADY;
      @(posedge S_AXI_ACLK); #1; t++;
    end while (!hs && t < 200);
    if (!hs) timeout("ar_handshake");
    S_AXI_ARVALID = 1'b0;
    t = 0;
    do begin
      @(negedge S_AXI_ACLK); hs = S_AXI_RVALID; d = S_AXI_RDATA;
      @(posedge S_AXI_ACLK); #1; t++;
    end while (!hs && t < 200);
    if (!hs) timeout("r_handshake");
  endtask

  task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    repeat (3) @(posedge S_AXI_ACLK);
    #1 S_AXI_ARESETN = 1'b1;
    read_expect("rst_maxlen", ADDR_MAXLEN, 32'd0);
    read_expect("rst_pktcount", ADDR_PKTCOUNT, 32'd0);
    read_expect("rst_lastlen", ADDR_LASTLEN, 32'd0);
    read_expect("rst_trunc", ADDR_TRUNC, 32'd0);

    send_pkt(1, 0); send_pkt(5, 0); send_pkt(300, 0);
    repeat (2) @(posedge S_AXI_ACLK); #1;
    read_expect("unl_pktcount", ADDR_PKTCOUNT, 32'd3);
    read_expect("unl_lastlen", ADDR_LASTLEN, 32'd300);
    read_expect("unl_trunc", ADDR_TRUNC, 32'd0);

    axil_write(ADDR_MAXLEN, 32'd4, 4'hF);
    read_expect("max4_readback", ADDR_MAXLEN, 32'd4);
    send_pkt(10, 0);
    read_expect("cut_trunc", ADDR_TRUNC, 32'd1);
    read_expect("cut_lastlen", ADDR_LASTLEN, 32'd4);
    read_expect("cut_pktcount", ADDR_PKTCOUNT, 32'd4);

    axil_write(ADDR_TRUNC, 32'd0, 4'hF);
    read_expect("clr_trunc", ADDR_TRUNC, 32'd0);
    send_pkt(4, 0);
    read_expect("exact_trunc", ADDR_TRUNC, 32'd0);
    read_expect("exact_lastlen", ADDR_LASTLEN, 32'd4);
    send_pkt(3, 0);
    read_expect("after_exact_lastlen", ADDR_LASTLEN, 32'd3);

    axil_write(ADDR_MAXLEN, 32'd0, 4'hF);
    fork
      send_pkt(6, 0);
      begin repeat (2) @(posedge S_AXI_ACLK); #1; axil_write(ADDR_MAXLEN, 32'd2, 4'hF); end
    join
    read_expect("midwr_lastlen", ADDR_LASTLEN, 32'd6);
    read_expect("midwr_trunc", ADDR_TRUNC, 32'd0);
    send_pkt(6, 0);
    read_expect("next_lastlen", ADDR_LASTLEN, 32'd2);
    read_expect("next_trunc", ADDR_TRUNC, 32'd1);
    read_expect("next_pktcount", ADDR_PKTCOUNT, 32'd8);

    axil_write(ADDR_MAXLEN, 32'h0000_1234, 4'b0011);
    axil_write(ADDR_MAXLEN, 32'hFFFF_FFFF, 4'b0010);
    read_expect("wstrb_maxlen", ADDR_MAXLEN, 32'h0000_FF34);
    axil_write(ADDR_PKTCOUNT, 32'hDEAD_BEEF, 4'hF);
    read_expect("ro_pktcount", ADDR_PKTCOUNT, 32'd8);
    axil_write(ADDR_MAXLEN, 32'd0, 4'hF);

    bp_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      fork
        send_pkt($urandom_range(1, 12), 1);
        begin
          repeat ($urandom_range(0, 6)) @(posedge S_AXI_ACLK);
          #1;
          case ($urandom_range(0, 3))
            0: axil_read(2'($urandom_range(0, 3)), rd_val);
            1: axil_write(ADDR_MAXLEN, $urandom_range(0, 8), 4'hF);
            2: axil_write(ADDR_TRUNC, 32'd0, 4'hF);
            default: ;
          endcase
        end
      join
    end
    bp_on = 1'b0;
    repeat (4) @(posedge S_AXI_ACLK); #1;

    axil_write(ADDR_MAXLEN, 32'd4, 4'hF);
    for (int i = 0; i < 6; i++) send_beat($urandom, 1'b0);
    S_AXI_ARESETN = 1'b0;
    repeat (3) @(posedge S_AXI_ACLK);
    #1 S_AXI_ARESETN = 1'b1;
    read_expect("rst2_maxlen", ADDR_MAXLEN, 32'd0);
    read_expect("rst2_pktcount", ADDR_PKTCOUNT, 32'd0);
    read_expect("rst2_lastlen", ADDR_LASTLEN, 32'd0);
    read_expect("rst2_trunc", ADDR_TRUNC, 32'd0);
    send_pkt(3, 0);
    read_expect("rst2_pkt_pktcount", ADDR_PKTCOUNT, 32'd1);
    read_expect("rst2_pkt_lastlen", ADDR_LASTLEN, 32'd3);

    repeat (4) @(posedge S_AXI_ACLK); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("b_drained", wr_pending, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
